// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and constants for the boot/program-load controller.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
        ST_ERR
    } boot_state_t;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned HDR_BYTES       = 2;
    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned WORD_W          = WORD_BYTES * BYTE_W;
    localparam int unsigned DEFAULT_TIMEOUT = 1000000;

    // States in which the controller takes bytes from the host.
    function automatic logic is_rx_state(input boot_state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Byte-serial valid/ready stream from the host into the boot controller.
interface cpu_boot_ctrl_if;
    import boot_pkg::*;

    logic              host_valid;
    logic [BYTE_W-1:0] host_data;
    logic              host_ready;

    modport master (output host_valid, output host_data, input host_ready);
    modport slave  (input host_valid, input host_data, output host_ready);

endinterface

// File: rtl/cpu_boot_ctrl_packer.sv
// Packs little-endian bytes into a 32-bit word; word_full pulses for one
// cycle after the last byte of a word lands.
module byte_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_full,
    output logic              last_c
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;

    // Next accepted byte completes the word.
    assign last_c = (cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            word      <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= 1'b0;
            if (clear) begin
                cnt  <= '0;
                word <= '0;
            end else if (accept) begin
                word      <= {data, word[WORD_W-1:BYTE_W]};
                cnt       <= cnt + CNT_W'(1);
                word_full <= last_c;
            end
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot controller: holds the core in reset, streams a program image from the
// host into instruction RAM, then releases the core to fetch from PC 0.
module cpu_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned TIMEOUT        = DEFAULT_TIMEOUT,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic                 clck,
    input  logic                 rst,
    input  logic                 load_req,
    cpu_boot_ctrl_if.slave       host,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_W-1:0]    imem_wdata,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      words_loaded
);

    localparam int unsigned HDR_W = HDR_BYTES * BYTE_W;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned RC_W  = $clog2(RELEASE_CYCLES + 1);
    localparam int unsigned WL_W  = ADDR_W + 1;

    boot_state_t       state;
    logic [BYTE_W-1:0] n_lo;
    logic [HDR_W-1:0]  hdr;
    logic [ADDR_W-1:0] last_idx;
    logic [TO_W-1:0]   tcnt;
    logic [RC_W-1:0]   rcnt;
    logic              from_write;
    logic              accept;
    logic              pk_clear;
    logic              pk_last_c;

    assign host.host_ready = is_rx_state(state);
    assign accept          = host.host_valid && host.host_ready;
    assign hdr             = {host.host_data, n_lo};
    assign pk_clear        = load_req && ((state == ST_IDLE) || (state == ST_ERR));

    // imem_we/imem_wdata come straight from the packer's registers.
    byte_packer u_packer (
        .clk       (clck),
        .rst       (rst),
        .accept    (accept && (state == ST_DATA)),
        .clear     (pk_clear),
        .data      (host.host_data),
        .word      (imem_wdata),
        .word_full (imem_we),
        .last_c    (pk_last_c)
    );

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state        <= ST_RELEASE;
            cpu_rst_n    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            imem_addr    <= '0;
            n_lo         <= '0;
            last_idx     <= '0;
            tcnt         <= '0;
            rcnt         <= '0;
            from_write   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RELEASE: begin
                    if (rcnt == RC_W'(RELEASE_CYCLES - 1)) begin
                        state      <= ST_IDLE;
                        cpu_rst_n  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= from_write;
                        from_write <= 1'b0;
                    end else begin
                        rcnt <= rcnt + RC_W'(1);
                    end
                end
                ST_IDLE, ST_ERR: begin
                    if (load_req) begin
                        state        <= ST_HDR0;
                        cpu_rst_n    <= 1'b0;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= '0;
                        tcnt         <= '0;
                    end
                end
                ST_HDR0, ST_HDR1, ST_DATA: begin
                    if (accept) begin
                        tcnt <= '0;
                        case (state)
                            ST_HDR0: begin
                                n_lo  <= host.host_data;
                                state <= ST_HDR1;
                            end
                            ST_HDR1: begin
                                if ((hdr == '0) || (32'(hdr) > DEPTH)) begin
                                    state <= ST_ERR;
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    last_idx <= ADDR_W'(hdr - HDR_W'(1));
                                    state    <= ST_DATA;
                                end
                            end
                            default: begin
                                if (pk_last_c) begin
                                    state        <= ST_WRITE;
                                    words_loaded <= words_loaded + WL_W'(1);
                                end
                            end
                        endcase
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        // Host went silent; keep whatever was already written.
                        state <= ST_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (imem_addr == last_idx) begin
                        state      <= ST_RELEASE;
                        rcnt       <= '0;
                        from_write <= 1'b1;
                    end else begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        state     <= ST_DATA;
                    end
                end
                default: state <= ST_RELEASE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Randomised self-checking bench for cpu_boot_ctrl against a byte-stream
// reference model of the program image.
module tb_cpu_boot_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned TO     = 16;
    localparam int unsigned RC     = 2;

    logic              clck = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    cpu_boot_ctrl_if host_if ();

    cpu_boot_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(4096), .TIMEOUT(TO), .RELEASE_CYCLES(RC)
    ) dut (
        .clck(clck), .rst(rst), .load_req(load_req), .host(host_if),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clck = ~clck;

    int total = 0;
    int bad   = 0;

    // Passive monitor: records writes, done pulses and core-release times.
    int                cyc = 0;
    int                we_wide = 0;
    int                done_cnt = 0;
    int                last_we_cyc = -1;
    int                rise_cyc = -1;
    logic              prev_we = 1'b0;
    logic              prev_rn = 1'b0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    always @(negedge clck) begin
        cyc <= cyc + 1;
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            last_we_cyc <= cyc + 1;
            if (prev_we) we_wide <= we_wide + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (cpu_rst_n && !prev_rn) rise_cyc <= cyc + 1;
        prev_we <= imem_we;
        prev_rn <= cpu_rst_n;
    end

    // Reference image: header is the word count, words go out low byte first.
    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];

    task automatic build_load(input int n);
        logic [31:0] w;
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(8'(n));
        tx_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            exp_q.push_back(w);
            for (int b = 0; b < 4; b++) tx_q.push_back(8'(w >> (8 * b)));
        end
    endtask

    task automatic send_bytes(input int from, input int upto, input int pct);
        for (int i = from; i < upto; i++) begin
            int   waited;
            logic acc;
            waited = 0;
            acc    = 1'b0;
            while (!acc) begin
                host_if.host_valid = ($urandom_range(99) < pct);
                host_if.host_data  = tx_q[i];
                @(negedge clck);
                acc = host_if.host_valid && host_if.host_ready;
                @(posedge clck);
                #1;
                waited++;
                if (!acc && waited > 400) begin
                    total++;
                    bad++;
                    $display("FAIL send_byte idx=%0d not accepted after %0d cycles", i, waited);
                    host_if.host_valid = 1'b0;
                    return;
                end
            end
        end
        host_if.host_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clck);
        #1;
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clck);
            #1;
            n++;
        end
        repeat (2) @(posedge clck);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle busy=%0b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        logic rn[4];
        logic bz[4];
        int   d0;
        rst = 1'b1;
        repeat (3) @(posedge clck);
        #1;
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL reset_cpu_rst_n got=%0b exp=0", cpu_rst_n); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%0b exp=1", busy); end
        total++; if ({done, err, imem_we, host_if.host_ready} !== 4'b0) begin
            bad++; $display("FAIL reset_flags done/err/we/ready got=%b exp=0000", {done, err, imem_we, host_if.host_ready});
        end
        total++; if ({words_loaded, imem_addr, imem_wdata} !== '0) begin
            bad++; $display("FAIL reset_regs wl=%0d addr=%0d wdata=%h exp all 0", words_loaded, imem_addr, imem_wdata);
        end
        d0  = done_cnt;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clck);
            rn[k] = cpu_rst_n;
            bz[k] = busy;
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rn[k] !== (k >= int'(RC)) || bz[k] !== (k < int'(RC))) begin
                bad++;
                $display("FAIL reset_release cycle=%0d cpu_rst_n=%0b busy=%0b exp %0b/%0b", k, rn[k], bz[k], k >= int'(RC), k < int'(RC));
            end
        end
        @(posedge clck);
        #1;
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL reset_done pulses=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_basic_load();
        int w0, d0;
        w0 = wa_q.size();
        d0 = done_cnt;
        pulse_load();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        send_bytes(0, tx_q.size(), 100);
        wait_idle("basic");
        total++; if (wa_q.size() - w0 !== 2) begin bad++; $display("FAIL basic_writes got=%0d exp=2", wa_q.size() - w0); end
        if (wa_q.size() >= w0 + 2) begin
            total++; if (wa_q[w0] !== 12'd0 || wd_q[w0] !== 32'h0010_0513) begin
                bad++; $display("FAIL basic_word0 addr=%0d data=%h exp 0/00100513", wa_q[w0], wd_q[w0]);
            end
            total++; if (wa_q[w0+1] !== 12'd1 || wd_q[w0+1] !== 32'h0010_0073) begin
                bad++; $display("FAIL basic_word1 addr=%0d data=%h exp 1/00100073", wa_q[w0+1], wd_q[w0+1]);
            end
        end
        total++; if (words_loaded !== 13'd2) begin bad++; $display("FAIL basic_words_loaded got=%0d exp=2", words_loaded); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done pulses=%0d exp=1", done_cnt - d0); end
        // Write cycle itself, then RC cycles of RELEASE before the core runs.
        total++; if (rise_cyc - last_we_cyc !== int'(RC) + 1) begin
            bad++; $display("FAIL basic_release_delay got=%0d exp=%0d", rise_cyc - last_we_cyc, RC + 1);
        end
        total++; if (cpu_rst_n !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL basic_final cpu_rst_n=%0b err=%0b exp 1/0", cpu_rst_n, err);
        end
    endtask

    task automatic test_random_stall();
        int w0, d0, wide0;
        w0    = wa_q.size();
        d0    = done_cnt;
        wide0 = we_wide;
        build_load(3);
        pulse_load();
        send_bytes(0, tx_q.size(), 30);
        wait_idle("random");
        total++; if (wa_q.size() - w0 !== 3) begin bad++; $display("FAIL random_writes got=%0d exp=3", wa_q.size() - w0); end
        for (int i = 0; i < 3 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wa_q[w0+i] !== ADDR_W'(i) || wd_q[w0+i] !== exp_q[i]) begin
                bad++; $display("FAIL random_word%0d addr=%0d data=%h exp %0d/%h", i, wa_q[w0+i], wd_q[w0+i], i, exp_q[i]);
            end
        end
        total++; if (we_wide !== wide0) begin bad++; $display("FAIL random_we_width wide_pulses=%0d exp=0", we_wide - wide0); end
        total++; if (words_loaded !== 13'd3 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL random_status wl=%0d done=%0d exp 3/1", words_loaded, done_cnt - d0);
        end
    endtask

    task automatic test_bad_header();
        int w0, d0;
        w0 = wa_q.size();
        d0 = done_cnt;
        pulse_load();
        tx_q = '{8'h00, 8'h00};
        send_bytes(0, 2, 100);
        repeat (3) @(posedge clck);
        #1;
        total++; if ({err, cpu_rst_n, busy, host_if.host_ready} !== 4'b1000) begin
            bad++; $display("FAIL hdr_zero err/rst_n/busy/ready got=%b exp=1000", {err, cpu_rst_n, busy, host_if.host_ready});
        end
        pulse_load();
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL hdr_reload err=%0b busy=%0b exp 0/1", err, busy); end
        tx_q = '{8'h01, 8'h10};
        send_bytes(0, 2, 100);
        repeat (5) @(posedge clck);
        #1;
        total++; if ({err, cpu_rst_n, busy} !== 3'b100) begin
            bad++; $display("FAIL hdr_big err/rst_n/busy got=%b exp=100", {err, cpu_rst_n, busy});
        end
        total++; if (wa_q.size() !== w0 || done_cnt !== d0) begin
            bad++; $display("FAIL hdr_no_write writes=%0d done=%0d exp 0/0", wa_q.size() - w0, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int w0, n;
        w0 = wa_q.size();
        pulse_load();
        total++; if (words_loaded !== '0 || err !== 1'b0) begin
            bad++; $display("FAIL to_start wl=%0d err=%0b exp 0/0", words_loaded, err);
        end
        build_load(2);
        send_bytes(0, 6, 100);
        repeat (14) @(posedge clck);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_early err=%0b exp=0", err); end
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            @(posedge clck);
            #1;
            n++;
        end
        total++; if (err !== 1'b1 || cpu_rst_n !== 1'b0) begin
            bad++; $display("FAIL to_err err=%0b cpu_rst_n=%0b exp 1/0", err, cpu_rst_n);
        end
        total++; if (words_loaded !== 13'd1 || wa_q.size() - w0 !== 1) begin
            bad++; $display("FAIL to_partial wl=%0d writes=%0d exp 1/1", words_loaded, wa_q.size() - w0);
        end else begin
            total++; if (wd_q[w0] !== exp_q[0]) begin bad++; $display("FAIL to_word data=%h exp=%h", wd_q[w0], exp_q[0]); end
        end
        pulse_load();
        total++; if (err !== 1'b0 || words_loaded !== '0) begin
            bad++; $display("FAIL to_clear err=%0b wl=%0d exp 0/0", err, words_loaded);
        end
        w0 = wa_q.size();
        build_load(1);
        send_bytes(0, tx_q.size(), 100);
        wait_idle("to_recover");
        total++; if (wa_q.size() - w0 !== 1 || cpu_rst_n !== 1'b1) begin
            bad++; $display("FAIL to_recover writes=%0d cpu_rst_n=%0b exp 1/1", wa_q.size() - w0, cpu_rst_n);
        end
    endtask

    task automatic test_data_events();
        int w0, d0;
        w0 = wa_q.size();
        build_load(2);
        pulse_load();
        send_bytes(0, 4, 100);
        pulse_load();
        total++; if (busy !== 1'b1 || err !== 1'b0 || host_if.host_ready !== 1'b1) begin
            bad++; $display("FAIL ldreq_ignored busy=%0b err=%0b ready=%0b exp 1/0/1", busy, err, host_if.host_ready);
        end
        send_bytes(4, tx_q.size(), 60);
        wait_idle("ldreq");
        total++; if (wa_q.size() - w0 !== 2 || words_loaded !== 13'd2) begin
            bad++; $display("FAIL ldreq_writes writes=%0d wl=%0d exp 2/2", wa_q.size() - w0, words_loaded);
        end else begin
            total++; if (wd_q[w0] !== exp_q[0] || wd_q[w0+1] !== exp_q[1]) begin
                bad++; $display("FAIL ldreq_data got=%h/%h exp=%h/%h", wd_q[w0], wd_q[w0+1], exp_q[0], exp_q[1]);
            end
        end
        w0 = wa_q.size();
        d0 = done_cnt;
        build_load(2);
        pulse_load();
        send_bytes(0, 4, 100);
        rst = 1'b1;
        #1;
        total++; if ({imem_we, cpu_rst_n, busy, host_if.host_ready} !== 4'b0010 || words_loaded !== '0) begin
            bad++; $display("FAIL rst_mid we/rst_n/busy/ready=%b wl=%0d exp 0010/0", {imem_we, cpu_rst_n, busy, host_if.host_ready}, words_loaded);
        end
        @(posedge clck);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clck);
        #1;
        total++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || done_cnt !== d0 || wa_q.size() !== w0) begin
            bad++; $display("FAIL rst_mid_after rst_n=%0b busy=%0b done=%0d writes=%0d exp 1/0/0/0", cpu_rst_n, busy, done_cnt - d0, wa_q.size() - w0);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wa_q.size();
        build_load(1);
        host_if.host_valid = 1'b1;
        host_if.host_data  = 8'h05;
        pulse_load();
        host_if.host_valid = 1'b0;
        send_bytes(0, tx_q.size(), 100);
        wait_idle("b2b");
        total++; if (wa_q.size() - w0 !== 1 || words_loaded !== 13'd1) begin
            bad++; $display("FAIL b2b_writes writes=%0d wl=%0d exp 1/1", wa_q.size() - w0, words_loaded);
        end else begin
            total++; if (wa_q[w0] !== '0 || wd_q[w0] !== exp_q[0]) begin
                bad++; $display("FAIL b2b_word addr=%0d data=%h exp 0/%h", wa_q[w0], wd_q[w0], exp_q[0]);
            end
        end
    endtask

    initial begin
        host_if.host_valid = 1'b0;
        host_if.host_data  = '0;
        test_reset();
        test_basic_load();
        test_random_stall();
        test_bad_header();
        test_timeout();
        test_data_events();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
